// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave: FSM states, mode constants and
// clock polarity/phase decoding.
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } spi_state_t;

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;

  // Idle level of SCLK
  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  // 0: data valid before the first edge, 1: data launched on the first edge
  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling edge
  function automatic logic sample_on_rise(input logic [1:0] mode);
    return ~(cpol(mode) ^ cpha(mode));
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with edge detection on the
// synchronised level.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Move the pin through the synchroniser chain and keep the last synced value for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_shifter.sv
// Oversampling SPI slave: assembles WIDTH-bit frames from MOSI, shifts tx_data
// out on MISO, and aborts frames cut short by chip select.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODE        = 0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic [WIDTH-1:0] leds,
  output logic             busy
);

  localparam int             CW          = $clog2(WIDTH);
  localparam logic [1:0]     MODE_BITS   = 2'(MODE);
  localparam logic           PHASE       = cpha(MODE_BITS);
  localparam logic           SAMPLE_RISE = sample_on_rise(MODE_BITS);
  localparam logic [CW-1:0]  LAST_BIT    = CW'(WIDTH - 1);

  spi_state_t state, state_next;

  logic             sclk_level_unused;
  logic             sclk_rise, sclk_fall;
  logic             cs_level;
  logic             cs_rise_unused, cs_fall_unused;
  logic             mosi_level;
  logic             mosi_rise_unused, mosi_fall_unused;

  logic             sample_edge, launch_edge;
  logic             enter_active, leave_active, do_sample, do_launch;

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_data_adv, tx_shift_adv;
  logic             tx_data_first, tx_shift_out;
  logic             miso_q;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (cs_n),
    .level (cs_level),
    .rise  (cs_rise_unused),
    .fall  (cs_fall_unused)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (mosi),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign launch_edge = SAMPLE_RISE ? sclk_fall : sclk_rise;

  // Bit ordering: which end of a word goes on the wire first, and how the
  // shift registers move to expose the next bit.
  assign rx_next       = MSB_FIRST ? {shift_reg[WIDTH-2:0], mosi_level}
                                   : {mosi_level, shift_reg[WIDTH-1:1]};
  assign tx_data_first = MSB_FIRST ? tx_data[WIDTH-1] : tx_data[0];
  assign tx_data_adv   = MSB_FIRST ? {tx_data[WIDTH-2:0], 1'b0}
                                   : {1'b0, tx_data[WIDTH-1:1]};
  assign tx_shift_out  = MSB_FIRST ? tx_shift[WIDTH-1] : tx_shift[0];
  assign tx_shift_adv  = MSB_FIRST ? {tx_shift[WIDTH-2:0], 1'b0}
                                   : {1'b0, tx_shift[WIDTH-1:1]};

  // State register; reset parks in WAIT_IDLE so a frame already in flight is never joined
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle datapath strobes; chip select release outranks any SCLK edge
  always_comb begin
    state_next   = state;
    enter_active = 1'b0;
    leave_active = 1'b0;
    do_sample    = 1'b0;
    do_launch    = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (cs_level) state_next = IDLE;
      end
      IDLE: begin
        if (!cs_level) begin
          state_next   = ACTIVE;
          enter_active = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_level) begin
          state_next   = IDLE;
          leave_active = 1'b1;
        end else begin
          do_sample = sample_edge;
          do_launch = launch_edge;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  // Receive/transmit shifting, frame completion and abort detection
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_shift  <= '0;
      miso_q    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (enter_active) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
        if (PHASE) begin
          tx_shift <= tx_data;
          miso_q   <= 1'b0;
        end else begin
          tx_shift <= tx_data_adv;
          miso_q   <= tx_data_first;
        end
      end else if (leave_active) begin
        bit_cnt <= '0;
        miso_q  <= 1'b0;
        if (bit_cnt != '0) frame_err <= 1'b1;
      end else if (do_sample) begin
        shift_reg <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          tx_shift <= tx_data;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end else if (do_launch) begin
        miso_q   <= tx_shift_out;
        tx_shift <= tx_shift_adv;
      end
    end
  end

  assign busy = (state == ACTIVE);
  assign miso = busy & miso_q;
  assign leds = shift_reg;

endmodule
